bitcount_param: RTL and testbench

- Parametrised, multi-mode successor to the team's 8-bit shift-and-count bit counter.
- Loads an N-bit operand into an internal right-shift register, then iterates one bit per clock under a 3-state controller.
- Reports a result in one of three modes: count of ones, count of zeros, or trailing-zero count.
- Standalone datapath/control block for the lab designs, driven by switch/button-style start and load strobes.

---
 rtl/bitcount_param.sv | 127 ++++++++++++
 tb/tb_bitcount_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bitcount_param.sv
// Parametrised multi-mode bit counter.
// An N-bit operand is loaded into a right-shift register, then one bit is
// examined per clock. The result is the count of ones, the count of zeros, or
// the trailing-zero count of the loaded operand.
module bitcount_param #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 5
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          LA,
    input  logic          s,
    input  logic [1:0]    Mode,
    input  logic [N-1:0]  Data,
    output logic [CW-1:0] B,
    output logic          Done,
    output logic          Busy
);

    localparam int unsigned MW = 2;

    localparam logic [MW-1:0] MODE_ONES  = 2'b00;
    localparam logic [MW-1:0] MODE_ZEROS = 2'b01;
    localparam logic [MW-1:0] MODE_TZ    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [CW-1:0]   b_q, b_d;
    logic [CW-1:0]   k_q, k_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Mode 11 is reserved and behaves as a plain popcount.
    logic            is_tz;
    assign is_tz = (mode_q == MODE_TZ);

    // Next-state, datapath updates and Moore flag decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                b_d = '0;
                k_d = '0;
                if (LA) begin
                    mode_d = Mode;
                    // Counting zeros is a popcount of the inverted operand.
                    a_d    = (Mode == MODE_ZEROS) ? ~Data : Data;
                end
                if (s) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (is_tz) begin
                    // Stop on the first set bit, or after N zeros.
                    if (a_q[0] || (k_q == CW'(N))) begin
                        state_d = ST_DONE;
                    end else begin
                        a_d = a_q >> 1;
                        b_d = b_q + CW'(1);
                        k_d = k_q + CW'(1);
                    end
                end else begin
                    // Terminate early once no set bits remain.
                    if (a_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        a_d = a_q >> 1;
                        b_d = b_q + CW'(a_q[0]);
                    end
                end
            end

            ST_DONE: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_SHIFT);
    end

    // State, datapath and registered status flags.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= MODE_ONES;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign B    = b_q;
    assign Done = done_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_bitcount_param.sv
// Directed bench for bitcount_param: an 8-bit and a 16-bit instance.
module tb_bitcount_param;

    logic        Clock;
    logic        Resetn;

    logic        la8, s8;
    logic [1:0]  mode8;
    logic [7:0]  d8;
    logic [3:0]  b8;
    logic        done8, busy8;

    logic        la16, s16;
    logic [1:0]  mode16;
    logic [15:0] d16;
    logic [4:0]  b16;
    logic        done16, busy16;

    int          errors;
    int          checks;

    bitcount_param #(.N(8), .CW(4)) u_dut8 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .LA     (la8),
        .s      (s8),
        .Mode   (mode8),
        .Data   (d8),
        .B      (b8),
        .Done   (done8),
        .Busy   (busy8)
    );

    bitcount_param #(.N(16), .CW(5)) u_dut16 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .LA     (la16),
        .s      (s16),
        .Mode   (mode16),
        .Data   (d16),
        .B      (b16),
        .Done   (done16),
        .Busy   (busy16)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input bit wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic logic done_of(input bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic int b_of(input bit wide);
        return wide ? int'(b16) : int'(b8);
    endfunction

    task automatic drive(input bit wide, input logic la, input logic st,
                         input logic [1:0] md, input logic [15:0] dat);
        if (wide) begin
            la16 = la; s16 = st; mode16 = md; d16 = dat;
        end else begin
            la8 = la; s8 = st; mode8 = md; d8 = dat[7:0];
        end
    endtask

    // Count SHIFT edges until Busy drops, bounded.
    task automatic wait_done(input bit wide, output int edges);
        edges = 0;
        while (busy_of(wide) && edges < 200) begin
            step();
            edges++;
        end
    endtask

    // Load (optionally together with start), run to DONE, hold, then exit.
    task automatic run(input string tag, input bit wide, input bit same_edge,
                       input logic [1:0] md, input logic [15:0] dat,
                       input int exp_b, input int exp_edges);
        int edges;
        drive(wide, 1'b1, same_edge, md, dat);
        step();
        if (!same_edge) begin
            chk({tag, "_idle_after_load"}, int'(busy_of(wide)), 0);
            drive(wide, 1'b0, 1'b1, md, dat);
            step();
        end
        drive(wide, 1'b0, 1'b1, md, dat);
        chk({tag, "_busy"}, int'(busy_of(wide)), 1);
        wait_done(wide, edges);
        chk({tag, "_edges"}, edges, exp_edges);
        chk({tag, "_done"}, int'(done_of(wide)), 1);
        chk({tag, "_b"}, b_of(wide), exp_b);
        step();
        chk({tag, "_hold_b"}, b_of(wide), exp_b);
        chk({tag, "_hold_done"}, int'(done_of(wide)), 1);
        drive(wide, 1'b0, 1'b0, md, dat);
        step();
        chk({tag, "_exit_done"}, int'(done_of(wide)), 0);
        chk({tag, "_exit_b_held"}, b_of(wide), exp_b);
        step();
        chk({tag, "_exit_b_clr"}, b_of(wide), 0);
    endtask

    initial begin
        int edges;
        errors = 0;
        checks = 0;
        Resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
        #12;
        chk("rst_b8", int'(b8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_b16", int'(b16), 0);
        chk("rst_done16", int'(done16), 0);
        Resetn = 1'b1;
        step();
        chk("post_rst_busy8", int'(busy8), 0);

        // Popcount, separate load and start.
        run("t1_pop_b6", 1'b0, 1'b0, 2'b00, 16'h00B6, 5, 9);
        // Count zeros, load and start on the same edge.
        run("t2_zeros_f0", 1'b0, 1'b1, 2'b01, 16'h00F0, 4, 5);
        // Trailing zeros.
        run("t3_tz_08", 1'b0, 1'b0, 2'b10, 16'h0008, 3, 4);
        run("t3_tz_00", 1'b0, 1'b0, 2'b10, 16'h0000, 8, 9);
        run("t3_tz_01", 1'b0, 1'b1, 2'b10, 16'h0001, 0, 1);
        // Popcount boundaries.
        run("t4_pop_00", 1'b0, 1'b0, 2'b00, 16'h0000, 0, 1);
        run("t4_pop_ff", 1'b0, 1'b0, 2'b00, 16'h00FF, 8, 9);

        // LA pulsed during SHIFT is ignored.
        drive(1'b0, 1'b1, 1'b1, 2'b00, 16'h0003);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'b00, 16'h0003);
        step();
        drive(1'b0, 1'b1, 1'b1, 2'b01, 16'h00FF);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'b01, 16'h00FF);
        wait_done(1'b0, edges);
        chk("t5_la_ignored_edges", edges + 2, 3);
        chk("t5_la_ignored_b", int'(b8), 2);
        chk("t5_la_ignored_done", int'(done8), 1);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0003);
        step();
        step();

        // Reset in the middle of a run.
        drive(1'b0, 1'b1, 1'b1, 2'b00, 16'h0003);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'b00, 16'h0003);
        step();
        chk("t5_pre_rst_b", int'(b8), 1);
        chk("t5_pre_rst_busy", int'(busy8), 1);
        Resetn = 1'b0;
        #1;
        chk("t5_rst_b", int'(b8), 0);
        chk("t5_rst_done", int'(done8), 0);
        chk("t5_rst_busy", int'(busy8), 0);
        #2;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0003);
        Resetn = 1'b1;
        step();
        chk("t5_rel_busy", int'(busy8), 0);
        chk("t5_rel_done", int'(done8), 0);
        chk("t5_rel_b", int'(b8), 0);

        // Wide instance.
        run("t6_pop_ffff", 1'b1, 1'b0, 2'b00, 16'hFFFF, 16, 17);
        run("t6_rsvd_8001", 1'b1, 1'b1, 2'b11, 16'h8001, 2, 17);
        run("t6_tz_0000", 1'b1, 1'b0, 2'b10, 16'h0000, 16, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
